dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 189 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Single-port data memory behind a valid/ready request/response handshake.
//   One request may be outstanding at a time. Stores commit on their accept
//   edge. Loads read the array on the edge that enters RESP. Loads and stores
//   have the same response timing. A store response always carries zero data.
//
// Optional feature (macro DMEM_ERR_EN):
//   When the macro is defined, the port resp_err exists. A request with any
//   address bit above the word index set responds with resp_err=1 and zero
//   data, and its array write is suppressed. When the macro is not defined,
//   the upper address bits are ignored and addresses wrap modulo 4*DEPTH.
//
// Parameters:
//   DEPTH      number of 32-bit words (power of two, >= 4)
//   LATENCY    cycles from request acceptance to response (>= 1)
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   datapath presents a request
//   req_ready   responder is idle and can accept (registered)
//   req_write   1 = store, 0 = load
//   req_addr    byte address; bits [1:0] are ignored
//   req_wdata   store data
//   resp_valid  response available, held until resp_ready
//   resp_ready  datapath consumes the response
//   resp_rdata  load data, 0 for stores and errored requests
//   resp_err    address out of range (only with DMEM_ERR_EN)
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata
`ifdef DMEM_ERR_EN
    ,
    output logic        resp_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    // The counter holds LATENCY-2 as its largest value.
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          r_state;
    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_idx;
    logic            r_isStore;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic            r_reqReady;
    logic            r_respValid;
    logic [31:0]     r_rdata;
`ifdef DMEM_ERR_EN
    logic            r_respErr;
`endif

    logic [AW-1:0]   w_idx;
    logic            w_addrErr;
    logic            w_store;
    logic [AW-1:0]   w_rdIdx;
    logic            w_rdZero;
    logic [31:0]     w_rdData;
    logic            w_unusedAddrBits;

    assign w_idx = req_addr[AW+1:2];

`ifdef DMEM_ERR_EN
    assign w_addrErr        = |req_addr[31:AW+2];
    assign w_unusedAddrBits = ^req_addr[1:0];
`else
    assign w_addrErr        = 1'b0;
    assign w_unusedAddrBits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    // A store commits only on its accept edge.
    // A store is not accepted on an edge where reset is asserted.
    assign w_store = !rst && (r_state == IDLE) && req_valid && req_write && !w_addrErr;

    // The read happens on the edge that enters RESP.
    // With LATENCY=1, that edge is the accept edge, so the index comes
    // straight from the request. Otherwise the index comes from the
    // value captured at acceptance.
    assign w_rdIdx  = (r_state == IDLE) ? w_idx : r_idx;
    assign w_rdZero = (r_state == IDLE) ? (req_write | w_addrErr) : (r_isStore | r_err);
    assign w_rdData = w_rdZero ? 32'd0 : r_mem[w_rdIdx];

    assign req_ready  = r_reqReady;
    assign resp_valid = r_respValid;
    assign resp_rdata = r_rdata;
`ifdef DMEM_ERR_EN
    assign resp_err   = r_respErr;
`endif

    // The memory array has no reset, so its contents survive reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_idx] <= req_wdata;
        end
    end

    // The control FSM. req_ready and resp_valid are registered state
    // decodes that update together with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_reqReady  <= 1'b1;
            r_respValid <= 1'b0;
            r_rdata     <= 32'd0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_isStore   <= 1'b0;
            r_err       <= 1'b0;
`ifdef DMEM_ERR_EN
            r_respErr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_idx      <= w_idx;
                        r_isStore  <= req_write;
                        r_err      <= w_addrErr;
                        r_reqReady <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_respValid <= 1'b1;
                            r_rdata     <= w_rdData;
`ifdef DMEM_ERR_EN
                            r_respErr   <= w_addrErr;
`endif
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CW'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_respValid <= 1'b1;
                        r_rdata     <= w_rdData;
`ifdef DMEM_ERR_EN
                        r_respErr   <= r_err;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    // The response stays stable until the handshake edge.
                    // req_ready rises with the return to IDLE, so the next
                    // request can be accepted no earlier than the next edge.
                    if (resp_ready) begin
                        r_state     <= IDLE;
                        r_respValid <= 1'b0;
                        r_reqReady  <= 1'b1;
                        r_rdata     <= 32'd0;
`ifdef DMEM_ERR_EN
                        r_respErr   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Purpose:
//   Self-checking bench for dmem_responder. It runs a sequence of directed
//   steps and then a burst of randomized loads and stores. The expected
//   values come from a word-array reference model. The model holds the
//   memory contents, maps each address to its word index, and flags
//   out-of-range addresses. All comparisons use immediate assertions.
//   The bench follows the optional feature DMEM_ERR_EN in the same way
//   as the design.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
`ifdef DMEM_ERR_EN
    logic        resp_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata)
`ifdef DMEM_ERR_EN
        ,
        .resp_err   (resp_err)
`endif
    );

    always #5 clk = ~clk;

    // This watchdog stops a hung run with a visible failure.
    initial begin
        repeat (40000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Maps a byte address to a word index, wrapping modulo 4*DEPTH.
    function automatic int indexFor(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    // Returns 1 when the address lies beyond the array (only with range checking).
    function automatic bit errFor(input logic [31:0] addr);
`ifdef DMEM_ERR_EN
        return addr >= 32'(4 * DEPTH);
`else
        return (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one complete transaction against the model. The task waits
    // for req_ready (with a bound) and presents the request. It checks
    // the response latency, then holds resp_ready low for `hold` cycles.
    // When `pulse` is set, the task drives a stray store during the hold.
    // Finally the task completes the handshake.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold, input bit pulse);
        int          waitCnt;
        int          lat;
        int          idx;
        bit          expErr;
        logic [31:0] expData;
        waitCnt = 0;
        lat     = 0;
        while (req_ready !== 1'b1 && waitCnt < 20) begin
            @(posedge clk);
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("reqReadyBeforeAccept", 32'(req_ready), 32'd1);

        idx     = indexFor(addr);
        expErr  = errFor(addr);
        expData = (wr || expErr) ? 32'd0 : model[idx];
        if (wr && !expErr) model[idx] = wdata;

        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;

        while (resp_valid !== 1'b1 && lat < LATENCY + 8) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checkOutput("respLatency", 32'(lat), 32'(LATENCY - 1));

        for (int i = 0; i < hold; i++) begin
            checkOutput("holdValid", 32'(resp_valid), 32'd1);
            checkOutput("holdData", resp_rdata, expData);
            checkOutput("holdReqReady", 32'(req_ready), 32'd0);
            if (pulse && i == 0) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_wdata = ~wdata;
            end
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
        end

        checkOutput("respValid", 32'(resp_valid), 32'd1);
        checkOutput("respData", resp_rdata, expData);
`ifdef DMEM_ERR_EN
        checkOutput("respErr", 32'(resp_err), 32'(expErr));
`endif
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("respCleared", 32'(resp_valid), 32'd0);
        checkOutput("reqReadyAfterHandshake", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int          k;
        bit          wr;
        logic [31:0] addr;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetReqReady", 32'(req_ready), 32'd1);
        checkOutput("resetRespValid", 32'(resp_valid), 32'd0);
        checkOutput("resetRespData", resp_rdata, 32'd0);
`ifdef DMEM_ERR_EN
        checkOutput("resetRespErr", 32'(resp_err), 32'd0);
`endif
        rst = 1'b0;
        $display("[TB] reset released");

        // Fill every word, so later loads never see uninitialised data.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i * 4), $urandom, 0, 1'b0);
        end
        $display("[TB] array preloaded");

        // Store followed by a load of the same word.
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        applyStimulus(1'b0, 32'h10, 32'h0, 0, 1'b0);

        // A stalled load holds its response, and a stray request is ignored.
        applyStimulus(1'b0, 32'h10, 32'h0, 5, 1'b1);
        applyStimulus(1'b0, 32'h10, 32'h0, 0, 1'b0);

`ifdef DMEM_ERR_EN
        // An out-of-range store errors and leaves word 0 untouched.
        applyStimulus(1'b1, 32'h400, 32'h0BAD0BAD, 1, 1'b0);
        applyStimulus(1'b0, 32'h000, 32'h0, 0, 1'b0);
`else
        // An address beyond the array wraps onto a low word.
        applyStimulus(1'b1, 32'h404, 32'h1234, 0, 1'b0);
        applyStimulus(1'b0, 32'h004, 32'h0, 0, 1'b0);
`endif

        // Reset during the wait of a load aborts the load and keeps memory.
        applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 0, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortRespValid", 32'(resp_valid), 32'd0);
        checkOutput("abortReqReady", 32'(req_ready), 32'd1);
        checkOutput("abortRespData", resp_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("abortNoResponse", 32'(resp_valid), 32'd0);
        end
        applyStimulus(1'b0, 32'h20, 32'h0, 0, 1'b0);
        $display("[TB] directed steps done");

        // Randomized mix of loads and stores with random stalls.
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
`ifdef DMEM_ERR_EN
            k    = int'($urandom_range(0, 3));
            addr = (k == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
`else
            addr = $urandom;
`endif
            applyStimulus(wr, addr, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        $display("[TB] random phase done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
